acc_datapath_p: RTL and testbench
=================================

Name: acc_datapath_p

Overview:
Parametrised accumulator-machine datapath: PC, IR, MAR, MDR, ACC, zero/carry flags, extended ALU and an integrated multi-cycle sequential divider with a start/busy/done handshake.
Sits between the control FSM (which drives the load/select strobes) and the single-port instruction/data memory.
Replaces the fixed 16-bit datapath with an external divider: all widths are parametrised, every register holds explicitly, and the divide is owned internally.

Parameters:
DATA_W, 16, width of ACC/MDR/IR/memory data
ADDR_W, 8, width of PC/MAR/memory address
OPC_W, 8, opcode field width; DATA_W >= ADDR_W+OPC_W; IR[OPC_W-1:0]=opcode, IR[OPC_W+ADDR_W-1:OPC_W]=operand address

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
load_pc  in  1  update PC
mux_pc  in  1  0: PC+1, 1: IR address (jump)
load_mar  in  1  update MAR
mux_mar  in  1  0: PC, 1: IR address
load_mdr  in  1  MDR <= mem_q
load_ir  in  1  IR <= MDR
load_acc  in  1  update ACC
acc_sel  in  2  0 MDR, 1 ALU, 2 quotient, 3 remainder (see Optional Feature)
op_alu  in  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not ACC, 6 ACC<<1, 7 ACC>>1 (logical)
div_start  in  1  start divide ACC/MDR
mem_q  in  DATA_W  memory read data
opcode  out  OPC_W  IR opcode field
mem_addr  out  ADDR_W  = MAR
mem_d  out  DATA_W  = ACC
zflag  out  1  registered ACC==0
cflag  out  1  registered carry/borrow
div_busy  out  1  divider running
div_done  out  1  one-cycle completion pulse
div_zero  out  1  last divide had a zero divisor; held until next start
acc_q  out  DATA_W  ACC value
mdr_q  out  DATA_W  MDR value

Behaviour:
- Reset (rst=0, async): PC, IR, MAR, MDR, ACC, quotient and remainder = 0; zflag=1; cflag=0; div_busy=div_done=div_zero=0; divider returns to IDLE. Reset mid-divide aborts it with no div_done.
- All registers hold when their load strobe is 0. Every update takes effect at the next rising edge (1-cycle latency).
- PC+1 wraps modulo 2^ADDR_W (max -> 0).
- ALU is combinational on ACC and MDR; results truncate to DATA_W.
  - add: cflag = carry out. sub: cflag = borrow (ACC<MDR).
  - shl: cflag = ACC[DATA_W-1]. shr: cflag = ACC[0].
  - Other ops: cflag = 0.
  - cflag updates only when load_acc=1 and acc_sel=1.
- zflag <= (ACC_next==0) whenever ACC loads; otherwise holds. It is coherent with ACC in the same cycle.
- Divider FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE + div_start: capture ACC as dividend and MDR as divisor (pre-edge values); div_busy=1.
  - Divisor 0: skip RUN; go to DONE next cycle with quotient=all-ones, remainder=dividend, div_zero=1.
  - RUN: restoring, 1 bit/cycle, exactly DATA_W cycles, unsigned.
  - DONE: div_done=1 for one cycle; results latched; div_busy=0 in DONE.
  - Total: div_done asserts DATA_W+1 cycles after the start edge (2 cycles for a zero divisor).
- div_start while busy is ignored.
- Quotient/remainder registers hold the last completed result until the next completion. acc_sel=2 while busy loads the stale result; this is legal.
- load_acc and div_start in the same cycle: the divider captures the old ACC.
- mux_pc=1 and load_ir in the same cycle: PC uses the old IR.

Optional Feature:
DIV_REMAINDER_EN:
- Defined: acc_sel=3 loads the remainder.
- Undefined: the remainder register is not built; acc_sel=3 is treated as acc_sel=0 (MDR).
- Quotient, div_zero and handshake timing are unchanged in both cases.

Decomposition:
- Package datapath_pkg: ALU op codes, acc_sel codes, divider state enum, default widths.
- One sub-module, seq_divider (parametrised by DATA_W): start/busy/done/zero handshake plus quotient and remainder. Everything else stays flat in acc_datapath_p.

Test Plan:
- Reset with registers non-zero -> all registers 0, zflag=1, mem_addr=0, mem_d=0; assert rst mid-divide -> div_busy drops immediately, no div_done.
- Fetch: PC=0x05, load_mar(mux 0) -> mem_addr=0x05; mem_q=0x1203, load_mdr then load_ir -> opcode=0x03; mux_pc=1, load_pc -> PC=0x12.
- ALU: ACC=0xFFFF, MDR=0x0001, add -> ACC=0x0000, cflag=1, zflag=1; ACC=0x0003, MDR=0x0005, sub -> ACC=0xFFFE, cflag=1.
- Divide: ACC=100, MDR=7, div_start -> div_done exactly 17 cycles later, quotient 14; acc_sel=2 -> ACC=14; with DIV_REMAINDER_EN, acc_sel=3 -> ACC=2.
- Divide by zero: ACC=0x1234, MDR=0 -> div_done 2 cycles after start, div_zero=1, quotient 0xFFFF, remainder 0x1234.
- PC=0xFF, load_pc(mux 0) -> PC=0x00; div_start pulsed during RUN -> ignored, original result and timing unchanged.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared constants and types for the accumulator datapath
//
// Purpose : ALU operation codes, ACC source-select codes, divider state type
//           and default widths used by acc_datapath_p and seq_divider.
// Ports   : none (package)
package datapath_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_OPC_W  = 8;

    // op_alu encodings
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    // acc_sel encodings
    localparam logic [1:0] ACC_SEL_MDR = 2'd0;
    localparam logic [1:0] ACC_SEL_ALU = 2'd1;
    localparam logic [1:0] ACC_SEL_QUO = 2'd2;
    localparam logic [1:0] ACC_SEL_REM = 2'd3;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
//
// Purpose : start/busy/done handshake around a DATA_W-cycle restoring divide.
//           A zero divisor completes after one RUN cycle with quotient all-ones,
//           remainder = dividend and zero flag set (held until the next start).
// Build   : DIV_REMAINDER_EN defined -> remainder result register and port exist.
// Ports   : clk, rst_n (async active-low), start, dividend, divisor,
//           busy (RUN), done (one-cycle pulse in DONE), zero, quotient,
//           remainder (only with DIV_REMAINDER_EN).
module seq_divider
    import datapath_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic              zero,
`ifdef DIV_REMAINDER_EN
    output logic [DATA_W-1:0] remainder,
`endif
    output logic [DATA_W-1:0] quotient
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W-1:0] par_q, par_d;   // partial remainder
    logic [DATA_W-1:0] quo_q, quo_d;
    logic              zero_q, zero_d;
`ifdef DIV_REMAINDER_EN
    logic [DATA_W-1:0] rem_q, rem_d;
`endif

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] par_next;
    logic [DATA_W-1:0] dvd_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    always_comb begin
        shifted  = {par_q, dvd_q[DATA_W-1]};
        diff     = shifted - {1'b0, dsr_q};
        if (!diff[DATA_W]) begin
            par_next = diff[DATA_W-1:0];
            dvd_next = {dvd_q[DATA_W-2:0], 1'b1};
        end else begin
            par_next = shifted[DATA_W-1:0];
            dvd_next = {dvd_q[DATA_W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        par_d   = par_q;
        quo_d   = quo_q;
        zero_d  = zero_q;
`ifdef DIV_REMAINDER_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    par_d   = '0;
                    cnt_d   = '0;
                    zero_d  = 1'b0;
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (dsr_q == '0) begin
                    // dvd_q still holds the untouched dividend here
                    quo_d   = '1;
`ifdef DIV_REMAINDER_EN
                    rem_d   = dvd_q;
`endif
                    zero_d  = 1'b1;
                    state_d = DIV_DONE;
                end else begin
                    dvd_d = dvd_next;
                    par_d = par_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        quo_d   = dvd_next;
`ifdef DIV_REMAINDER_EN
                        rem_d   = par_next;
`endif
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            par_q   <= '0;
            quo_q   <= '0;
            zero_q  <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            par_q   <= par_d;
            quo_q   <= quo_d;
            zero_q  <= zero_d;
`ifdef DIV_REMAINDER_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign busy     = (state_q == DIV_RUN);
    assign done     = (state_q == DIV_DONE);
    assign zero     = zero_q;
    assign quotient = quo_q;
`ifdef DIV_REMAINDER_EN
    assign remainder = rem_q;
`endif

endmodule

// File: rtl/acc_datapath_p.sv
// rtl/acc_datapath_p.sv - parametrised accumulator-machine datapath
//
// Purpose : PC, IR, MAR, MDR, ACC, zero/carry flags, ALU and an owned
//           sequential divider. Every register holds unless its strobe is set.
// Build   : DIV_REMAINDER_EN defined -> acc_sel=3 loads the divide remainder;
//           otherwise acc_sel=3 loads MDR and no remainder register exists.
// Ports   : clk, rst (async active-low); control strobes load_pc/mux_pc,
//           load_mar/mux_mar, load_mdr, load_ir, load_acc/acc_sel, op_alu,
//           div_start; mem_q read data; outputs opcode, mem_addr (MAR),
//           mem_d (ACC), zflag, cflag, div_busy, div_done, div_zero,
//           acc_q, mdr_q.
module acc_datapath_p
    import datapath_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OPC_W  = DEF_OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_pc,
    input  logic              mux_pc,
    input  logic              load_mar,
    input  logic              mux_mar,
    input  logic              load_mdr,
    input  logic              load_ir,
    input  logic              load_acc,
    input  logic [1:0]        acc_sel,
    input  logic [2:0]        op_alu,
    input  logic              div_start,
    input  logic [DATA_W-1:0] mem_q,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              zflag,
    output logic              cflag,
    output logic              div_busy,
    output logic              div_done,
    output logic              div_zero,
    output logic [DATA_W-1:0] acc_q,
    output logic [DATA_W-1:0] mdr_q
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_d;
    logic [DATA_W-1:0] acc_d;
    logic              zflag_q, zflag_d;
    logic              cflag_q, cflag_d;

    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] div_quo;
`ifdef DIV_REMAINDER_EN
    logic [DATA_W-1:0] div_rem;
`endif

    assign ir_addr = ir_q[OPC_W+ADDR_W-1:OPC_W];

    // ALU on current ACC/MDR; add/sub use one extra bit for carry/borrow
    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        case (op_alu)
            ALU_ADD: begin
                alu_wide = {1'b0, acc_q} + {1'b0, mdr_q};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
            end
            ALU_SUB: begin
                alu_wide = {1'b0, acc_q} - {1'b0, mdr_q};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
            end
            ALU_AND: alu_res = acc_q & mdr_q;
            ALU_OR:  alu_res = acc_q | mdr_q;
            ALU_XOR: alu_res = acc_q ^ mdr_q;
            ALU_NOT: alu_res = ~acc_q;
            ALU_SHL: begin
                alu_res = {acc_q[DATA_W-2:0], 1'b0};
                alu_c   = acc_q[DATA_W-1];
            end
            ALU_SHR: begin
                alu_res = {1'b0, acc_q[DATA_W-1:1]};
                alu_c   = acc_q[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        acc_d   = acc_q;
        zflag_d = zflag_q;
        cflag_d = cflag_q;

        // ir_addr is the pre-edge IR, so a jump with load_ir uses the old IR
        if (load_pc)  pc_d  = mux_pc ? ir_addr : pc_q + ADDR_W'(1);
        if (load_mar) mar_d = mux_mar ? ir_addr : pc_q;
        if (load_mdr) mdr_d = mem_q;
        if (load_ir)  ir_d  = mdr_q;

        if (load_acc) begin
            case (acc_sel)
                ACC_SEL_MDR: acc_d = mdr_q;
                ACC_SEL_ALU: begin
                    acc_d   = alu_res;
                    cflag_d = alu_c;
                end
                ACC_SEL_QUO: acc_d = div_quo;
`ifdef DIV_REMAINDER_EN
                ACC_SEL_REM: acc_d = div_rem;
`endif
                default:     acc_d = mdr_q;
            endcase
            zflag_d = (acc_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            acc_q   <= '0;
            zflag_q <= 1'b1;
            cflag_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            acc_q   <= acc_d;
            zflag_q <= zflag_d;
            cflag_q <= cflag_d;
        end
    end

    // Divider samples acc_q/mdr_q directly, so a same-cycle ACC load does
    // not disturb the captured dividend.
    seq_divider #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst),
        .start     (div_start),
        .dividend  (acc_q),
        .divisor   (mdr_q),
        .busy      (div_busy),
        .done      (div_done),
        .zero      (div_zero),
`ifdef DIV_REMAINDER_EN
        .remainder (div_rem),
`endif
        .quotient  (div_quo)
    );

    assign opcode   = ir_q[OPC_W-1:0];
    assign mem_addr = mar_q;
    assign mem_d    = acc_q;
    assign zflag    = zflag_q;
    assign cflag    = cflag_q;

endmodule

// File: tb/tb_acc_datapath_p.sv
// tb/tb_acc_datapath_p.sv - self-checking bench for acc_datapath_p
module tb_acc_datapath_p;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_pc, mux_pc, load_mar, mux_mar, load_mdr, load_ir, load_acc;
    logic [1:0]    acc_sel;
    logic [2:0]    op_alu;
    logic          div_start;
    logic [DW-1:0] mem_q;
    logic [OW-1:0] opcode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic          zflag, cflag, div_busy, div_done, div_zero;
    logic [DW-1:0] acc_q, mdr_q;

    int checks = 0;
    int errors = 0;

    acc_datapath_p #(.DATA_W(DW), .ADDR_W(AW), .OPC_W(OW)) dut (
        .clk(clk), .rst(rst),
        .load_pc(load_pc), .mux_pc(mux_pc), .load_mar(load_mar), .mux_mar(mux_mar),
        .load_mdr(load_mdr), .load_ir(load_ir), .load_acc(load_acc),
        .acc_sel(acc_sel), .op_alu(op_alu), .div_start(div_start), .mem_q(mem_q),
        .opcode(opcode), .mem_addr(mem_addr), .mem_d(mem_d),
        .zflag(zflag), .cflag(cflag), .div_busy(div_busy), .div_done(div_done),
        .div_zero(div_zero), .acc_q(acc_q), .mdr_q(mdr_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        load_pc = 0; mux_pc = 0; load_mar = 0; mux_mar = 0; load_mdr = 0;
        load_ir = 0; load_acc = 0; acc_sel = 0; op_alu = 0; div_start = 0;
    endtask

    // advance one rising edge, sample #1 later, drop strobes
    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    // ACC <- a, MDR <- b
    task automatic set_regs(input logic [DW-1:0] a, input logic [DW-1:0] b);
        mem_q = a; load_mdr = 1; cyc();
        mem_q = b; load_mdr = 1; load_acc = 1; acc_sel = 0; cyc();
    endtask

    task automatic read_pc(output logic [AW-1:0] pc);
        load_mar = 1; mux_mar = 0; cyc();
        pc = mem_addr;
    endtask

    // reference ALU from the arithmetic definition of each operation
    task automatic ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op,
                           output logic [DW-1:0] r, output logic c);
        int unsigned ua, ub, s;
        ua = a; ub = b; c = 0; r = 0;
        case (op)
            3'd0: begin s = ua + ub; r = DW'(s % 65536); c = (s > 65535); end
            3'd1: begin r = DW'((ua + 65536 - ub) % 65536); c = (ua < ub); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = DW'(65535 - ua);
            3'd6: begin r = DW'((ua * 2) % 65536); c = (ua >= 32768); end
            default: begin r = DW'(ua / 2); c = (ua % 2 == 1); end
        endcase
    endtask

    task automatic alu_apply(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op,
                             input logic [DW-1:0] er, input logic ec, input string tag);
        set_regs(a, b);
        load_acc = 1; acc_sel = 1; op_alu = op; cyc();
        chk({tag, "_acc"}, acc_q, er);
        chk({tag, "_cflag"}, cflag, ec);
        chk({tag, "_zflag"}, zflag, er == 0);
    endtask

    task automatic do_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit same_load, input bit mid_start, input string tag);
        int n;
        logic [DW-1:0] eq, er;
        if (b == 0) begin eq = 16'hFFFF; er = a; end
        else begin eq = DW'(a / b); er = DW'(a % b); end
        set_regs(a, b);
        div_start = 1;
        if (same_load) begin load_acc = 1; acc_sel = 0; end
        cyc();
        n = 1;
        chk({tag, "_busy_after_start"}, div_busy, 1);
        chk({tag, "_zero_cleared"}, div_zero, 0);
        while (!div_done && n < 60) begin
            if (mid_start && n == 4) div_start = 1;
            cyc();
            n++;
        end
        chk({tag, "_latency"}, n, (b == 0) ? 2 : 17);
        chk({tag, "_busy_in_done"}, div_busy, 0);
        chk({tag, "_div_zero"}, div_zero, b == 0);
        load_acc = 1; acc_sel = 2; cyc();
        chk({tag, "_done_pulse"}, div_done, 0);
        chk({tag, "_quotient"}, acc_q, eq);
        load_acc = 1; acc_sel = 3; cyc();
`ifdef DIV_REMAINDER_EN
        chk({tag, "_remainder"}, acc_q, er);
`else
        chk({tag, "_sel3_mdr"}, acc_q, b);
`endif
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
        logic [DW-1:0] er;
        logic          ec;
    } alu_vec_t;

    alu_vec_t tbl[13];

    initial begin
        logic [AW-1:0] pc;
        logic [DW-1:0] ra, rb, rr;
        logic [2:0]    rop;
        logic          rc;
        int            n, dones;

        tbl[0]  = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1};
        tbl[1]  = '{16'h0003, 16'h0005, 3'd1, 16'hFFFE, 1'b1};
        tbl[2]  = '{16'h0001, 16'h0002, 3'd0, 16'h0003, 1'b0};
        tbl[3]  = '{16'h0005, 16'h0003, 3'd1, 16'h0002, 1'b0};
        tbl[4]  = '{16'hF0F0, 16'h3C3C, 3'd2, 16'h3030, 1'b0};
        tbl[5]  = '{16'hF0F0, 16'h0F0F, 3'd3, 16'hFFFF, 1'b0};
        tbl[6]  = '{16'hAAAA, 16'hFFFF, 3'd4, 16'h5555, 1'b0};
        tbl[7]  = '{16'h00FF, 16'h1234, 3'd5, 16'hFF00, 1'b0};
        tbl[8]  = '{16'h8001, 16'h0000, 3'd6, 16'h0002, 1'b1};
        tbl[9]  = '{16'h0003, 16'h0000, 3'd7, 16'h0001, 1'b1};
        tbl[10] = '{16'h4000, 16'h0000, 3'd6, 16'h8000, 1'b0};
        tbl[11] = '{16'h0002, 16'h0000, 3'd7, 16'h0001, 1'b0};
        tbl[12] = '{16'h1234, 16'h1234, 3'd4, 16'h0000, 1'b0};

        clr();
        mem_q = 0;
        rst = 0;
        #22;
        rst = 1;
        cyc();

        // ---- reset with registers loaded ----
        set_regs(16'h1234, 16'h5678);
        load_ir = 1; load_pc = 1; cyc();
        load_mar = 1; mux_mar = 1; cyc();
        rst = 0;
        #1;
        chk("rst_acc", acc_q, 0);
        chk("rst_mdr", mdr_q, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_d", mem_d, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_zflag", zflag, 1);
        chk("rst_cflag", cflag, 0);
        chk("rst_div_flags", {div_busy, div_done, div_zero}, 0);
        #2 rst = 1;
        cyc();
        read_pc(pc);
        chk("rst_pc", pc, 0);

        // ---- reset mid-divide ----
        set_regs(16'd50, 16'd3);
        div_start = 1; cyc();
        repeat (5) cyc();
        chk("middiv_busy_before", div_busy, 1);
        rst = 0;
        #1;
        chk("middiv_busy_dropped", div_busy, 0);
        #2 rst = 1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (div_done) dones++;
        end
        chk("middiv_no_done", dones, 0);

        // ---- fetch sequence ----
        repeat (5) begin load_pc = 1; mux_pc = 0; cyc(); end
        read_pc(pc);
        chk("fetch_mar_pc", pc, 8'h05);
        mem_q = 16'h1203; load_mdr = 1; cyc();
        load_ir = 1; cyc();
        chk("fetch_opcode", opcode, 8'h03);
        load_mar = 1; mux_mar = 1; cyc();
        chk("fetch_mar_ir", mem_addr, 8'h12);
        load_pc = 1; mux_pc = 1; cyc();
        read_pc(pc);
        chk("fetch_jump_pc", pc, 8'h12);
        // jump with simultaneous IR load uses the old IR
        mem_q = 16'h3407; load_mdr = 1; cyc();
        load_pc = 1; mux_pc = 1; load_ir = 1; cyc();
        chk("jump_ir_opcode", opcode, 8'h07);
        read_pc(pc);
        chk("jump_old_ir_pc", pc, 8'h12);

        // ---- PC wrap ----
        mem_q = 16'hFF00; load_mdr = 1; cyc();
        load_ir = 1; cyc();
        load_pc = 1; mux_pc = 1; cyc();
        read_pc(pc);
        chk("wrap_pc_ff", pc, 8'hFF);
        load_pc = 1; mux_pc = 0; cyc();
        read_pc(pc);
        chk("wrap_pc_00", pc, 8'h00);

        // ---- ALU table ----
        for (int i = 0; i < 13; i++)
            alu_apply(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].er, tbl[i].ec, $sformatf("alu_tbl%0d", i));

        // cflag and ACC hold when not loading the ALU result
        alu_apply(16'hFFFF, 16'h0002, 3'd0, 16'h0001, 1'b1, "alu_hold_setup");
        repeat (3) cyc();
        chk("hold_acc", acc_q, 16'h0001);
        chk("hold_mem_d", mem_d, 16'h0001);
        load_acc = 1; acc_sel = 0; cyc();
        chk("cflag_hold_sel0", cflag, 1);
        chk("zflag_sel0", zflag, 0);

        // ---- randomized ALU against the model ----
        for (int i = 0; i < 40; i++) begin
            ra  = DW'($urandom);
            rb  = (i % 5 == 0) ? ra : DW'($urandom);
            rop = 3'($urandom_range(0, 7));
            ref_alu(ra, rb, rop, rr, rc);
            alu_apply(ra, rb, rop, rr, rc, $sformatf("alu_rnd%0d_op%0d", i, rop));
        end

        // ---- divides ----
        do_div(16'd100, 16'd7, 1'b0, 1'b0, "div_100_7");
        do_div(16'h1234, 16'd0, 1'b0, 1'b0, "div_zero");
        repeat (4) cyc();
        chk("div_zero_held", div_zero, 1);
        do_div(16'd100, 16'd7, 1'b1, 1'b1, "div_sameload_midstart");
        do_div(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "div_ffff_ffff");
        do_div(16'h0005, 16'h0009, 1'b0, 1'b0, "div_small");
        do_div(16'hFFFF, 16'h0001, 1'b0, 1'b0, "div_by_one");
        for (int i = 0; i < 6; i++) begin
            ra = DW'($urandom);
            rb = (i == 2) ? 16'd0 : ((i % 2 == 0) ? DW'($urandom_range(1, 255)) : DW'($urandom_range(1, 65535)));
            do_div(ra, rb, 1'b0, 1'b0, $sformatf("div_rnd%0d", i));
        end

        // ---- stale quotient while busy ----
        do_div(16'd100, 16'd7, 1'b0, 1'b0, "stale_setup");
        set_regs(16'd1000, 16'd10);
        div_start = 1; cyc();
        cyc();
        load_acc = 1; acc_sel = 2; cyc();
        chk("stale_quotient", acc_q, 16'd14);
        chk("stale_still_busy", div_busy, 1);
        n = 3;
        while (!div_done && n < 60) begin cyc(); n++; end
        chk("stale_latency", n, 17);
        load_acc = 1; acc_sel = 2; cyc();
        chk("stale_new_quotient", acc_q, 16'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
